// File: rtl/shot_controller.sv
// One-shot fire controller: turns a fire key level into a single bullet pulse,
// then waits out the bullet's flight and a cooldown before accepting the next shot.
module shot_controller #(
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned FLIGHT_TIMEOUT  = 127
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire_key,
  input  logic [3:0] direction,
  input  logic       bullet_exists,
  output logic       shoot_bullet,
  output logic [3:0] shot_dir,
  output logic       busy,
  output logic [7:0] shot_count,
  output logic [1:0] dbg_state,
  output logic       dbg_armed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    FLIGHT = 2'd2,
    COOL   = 2'd3
  } state_t;

  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] TIMEOUT   = 8'(FLIGHT_TIMEOUT);

  state_t     state_q;
  logic       armed_q;
  logic       shoot_q;
  logic       busy_q;
  logic [3:0] dir_q;
  logic [7:0] count_q;
  logic [7:0] flight_q;
  logic [7:0] cool_q;

  logic       dir_valid_d;
  logic [7:0] flight_d;
  logic       flight_exit_d;

  assign dir_valid_d   = (direction == 4'b1000) || (direction == 4'b0100) ||
                         (direction == 4'b0010) || (direction == 4'b0001);
  assign flight_d      = flight_q + 8'd1;
  // The first FLIGHT frame cannot end on bullet_exists: the bullet block may not have raised it yet.
  assign flight_exit_d = (!bullet_exists && (flight_q != 8'd0)) || (flight_d == TIMEOUT);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      shoot_q  <= 1'b0;
      busy_q   <= 1'b0;
      dir_q    <= 4'b0000;
      count_q  <= 8'd0;
      flight_q <= 8'd0;
      cool_q   <= 8'd0;
    end else begin
      shoot_q <= 1'b0;
      if (!fire_key) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (armed_q && fire_key && dir_valid_d) begin
            state_q <= FIRE;
            shoot_q <= 1'b1;
            busy_q  <= 1'b1;
            dir_q   <= direction;
            armed_q <= 1'b0;
          end
        end
        FIRE: begin
          state_q  <= FLIGHT;
          flight_q <= 8'd0;
          count_q  <= count_q + 8'd1;
        end
        FLIGHT: begin
          flight_q <= flight_d;
          if (flight_exit_d) begin
            if (COOL_INIT == 8'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= COOL;
              cool_q  <= COOL_INIT;
            end
          end
        end
        COOL: begin
          cool_q <= cool_q - 8'd1;
          if (cool_q == 8'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shoot_bullet = shoot_q;
  assign shot_dir     = dir_q;
  assign busy         = busy_q;
  assign shot_count   = count_q;
  assign dbg_state    = state_q;
  assign dbg_armed    = armed_q;

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: shot-timeline reference model compared every frame,
// directed scenarios with literal expectations, and a randomized soak.
module tb_shot_controller;

  localparam int COOL = 8;
  localparam int TOUT = 127;

  logic       clk;
  logic       rst;
  logic       key;
  logic [3:0] dir;
  logic       be;
  logic       shoot_bullet;
  logic [3:0] shot_dir;
  logic       busy;
  logic [7:0] shot_count;
  logic [1:0] dbg_state;
  logic       dbg_armed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  shot_controller #(.COOLDOWN_FRAMES(COOL), .FLIGHT_TIMEOUT(TOUT)) dut (
    .frame_clk(clk), .Reset(rst), .fire_key(key), .direction(dir),
    .bullet_exists(be), .shoot_bullet(shoot_bullet), .shot_dir(shot_dir),
    .busy(busy), .shot_count(shot_count), .dbg_state(dbg_state), .dbg_armed(dbg_armed)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a shot is a timeline measured in frames since it was accepted.
  // age 0 is the pulse frame, flight follows, and the cooldown starts at end_age.
  bit         m_in_shot = 0;
  int         m_age     = 0;
  int         m_end_age = -1;
  bit         m_armed   = 0;
  logic [7:0] m_cnt     = 8'd0;
  logic [3:0] m_dir     = 4'd0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_in_shot = 0; m_age = 0; m_end_age = -1;
        m_armed = 0; m_cnt = 8'd0; m_dir = 4'd0;
      end else if (!m_in_shot) begin
        if (m_armed && key && $countones(dir) == 1) begin
          m_in_shot = 1; m_age = 0; m_end_age = -1;
          m_dir = dir; m_armed = 0;
        end else if (!key) begin
          m_armed = 1;
        end
      end else begin
        if (!key) m_armed = 1;
        if (m_age == 0) m_cnt = m_cnt + 8'd1;
        else if (m_end_age < 0 && ((!be && m_age >= 2) || m_age == TOUT)) m_end_age = m_age + 1;
        m_age++;
        if (m_end_age >= 0 && m_age == m_end_age + COOL) m_in_shot = 0;
      end
    end
  end

  // scoreboard compare, one frame at a time
  always @(negedge clk) begin
    if (shoot_bullet) pulses++;
    check("shoot_bullet", int'(shoot_bullet), int'(m_in_shot && m_age == 0));
    check("busy", int'(busy), int'(m_in_shot));
    check("shot_dir", int'(shot_dir), int'(m_dir));
    check("shot_count", int'(shot_count), int'(m_cnt));
    check("armed", int'(dbg_armed), int'(m_armed));
  end

  // driver tasks: inputs change just after a falling edge, results read one frame later
  task automatic tick(input bit k, input logic [3:0] d, input bit b);
    key = k; dir = d; be = b;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(0, 4'b0001, 0);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic quick_shot();
    tick(0, 4'b0001, 0);
    tick(1, 4'b0001, 0);
    wait_idle(60);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_shoot", int'(shoot_bullet), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dir", int'(shot_dir), 0);
    check("rst_count", int'(shot_count), 0);
    check("rst_armed", int'(dbg_armed), 0);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [3:0] dir_tbl [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1100};

  initial begin
    int n;
    int p0;
    rst = 1'b1; key = 1'b0; dir = 4'd0; be = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("init_count", int'(shot_count), 0);
    check("init_busy", int'(busy), 0);
    rst = 1'b0;

    // first shot: key must be seen low after reset
    tick(1, 4'b0001, 0);
    check("no_shot_unarmed", int'(busy), 0);
    tick(0, 4'b0001, 0);
    check("armed_after_low", int'(dbg_armed), 1);
    tick(1, 4'b0001, 0);
    check("first_pulse", int'(shoot_bullet), 1);
    check("first_dir", int'(shot_dir), 4'b0001);
    tick(1, 4'b0001, 1);
    check("pulse_one_frame", int'(shoot_bullet), 0);
    check("first_count", int'(shot_count), 1);

    // held key for 300 frames: bullet lives 60 frames, still one shot
    for (int i = 0; i < 300; i++) tick(1, 4'b0001, i < 59);
    check("held_pulses", pulses, 1);
    check("held_count", int'(shot_count), 1);
    check("held_idle", int'(busy), 0);

    // long flight, heading changes ignored, presses during cooldown ignored
    tick(0, 4'b0010, 0);
    tick(1, 4'b0010, 0);
    check("second_pulse", int'(shoot_bullet), 1);
    for (int i = 0; i < 60; i++) tick(i[0], 4'b0100, 1);
    check("dir_hold_flight", int'(shot_dir), 4'b0010);
    tick(0, 4'b1000, 0);
    for (int i = 0; i < 7; i++) tick(i[0], 4'b1000, 0);
    check("cool_busy", int'(busy), 1);
    tick(1, 4'b1000, 0);
    check("cool_end_idle", int'(busy), 0);
    check("no_same_edge_fire", int'(shoot_bullet), 0);
    check("cool_pulses", pulses, 2);
    tick(1, 4'b1000, 0);
    check("post_cool_pulse", int'(shoot_bullet), 1);
    check("post_cool_dir", int'(shot_dir), 4'b1000);
    wait_idle(60);

    // stuck bullet: FIRE + timeout flight + cooldown
    tick(0, 4'b0001, 1);
    tick(1, 4'b0001, 1);
    n = 1;
    for (int i = 0; i < 400 && busy; i++) begin
      tick(0, 4'b0001, 1);
      if (busy) n++;
    end
    check("stuck_busy_frames", n, 1 + TOUT + COOL);

    // reset in flight with count 5, held key blocked until released
    do_reset();
    repeat (4) quick_shot();
    tick(0, 4'b0001, 0);
    tick(1, 4'b0001, 1);
    tick(1, 4'b0001, 1);
    tick(1, 4'b0001, 1);
    check("count_five", int'(shot_count), 5);
    check("in_flight", int'(busy), 1);
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 5; i++) tick(1, 4'b0001, 0);
    check("held_after_reset", pulses - p0, 0);
    tick(0, 4'b0001, 0);
    tick(1, 4'b0001, 0);
    check("after_release_pulse", int'(shoot_bullet), 1);
    wait_idle(60);

    // randomized soak
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 2) != 0, dir_tbl[$urandom_range(0, 5)], $urandom_range(0, 9) != 0);
    tick(0, 4'b0001, 0);
    wait_idle(200);

    // 256 shots wrap the counter; invalid heading keeps the shot armed
    do_reset();
    p0 = pulses;
    repeat (256) quick_shot();
    check("wrap_count", int'(shot_count), 0);
    check("wrap_pulses", pulses - p0, 256);
    tick(0, 4'b0001, 0);
    for (int i = 0; i < 3; i++) tick(1, 4'b1100, 0);
    check("invalid_no_shot", int'(busy), 0);
    check("invalid_armed", int'(dbg_armed), 1);
    tick(1, 4'b0100, 0);
    check("valid_after_invalid", int'(shoot_bullet), 1);
    check("valid_dir", int'(shot_dir), 4'b0100);
    wait_idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 SHALL have parameter COOLDOWN_FRAMES, default 8, meaning the number of frames after a shot ends before the next shot is accepted (range 0..255).
REQ-002 SHALL have parameter FLIGHT_TIMEOUT, default 127, meaning the maximum number of frames spent waiting for bullet_exists to fall (range 1..255).
REQ-003 SHALL have port frame_clk, input, 1 bit: the sole clock, one rising edge per video frame.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port fire_key, input, 1 bit: fire button level from the keyboard decoder, synchronous to frame_clk.
REQ-006 SHALL have port direction, input, 4 bits: ship heading, where 1000 = up, 0100 = down, 0010 = left, 0001 = right.
REQ-007 SHALL have port bullet_exists, input, 1 bit: the exists flag returned by the downstream bullet block.
REQ-008 SHALL have port shoot_bullet, output, 1 bit: a one-frame fire pulse to the bullet block.
REQ-009 SHALL have port shot_dir, output, 4 bits: the heading latched at the moment of firing.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port shot_count, output, 8 bits: total shots fired.

Function
REQ-012 SHALL implement the states IDLE, FIRE, FLIGHT and COOL, with all outputs registered.
REQ-013 SHALL keep an armed flag that is set on any edge where fire_key = 0 and cleared on entry to FIRE, so that a held key produces exactly one shot.
REQ-014 SHALL transition IDLE -> FIRE on an edge where armed = 1, fire_key = 1 and direction is a valid one-hot heading.
REQ-015 SHALL, on an IDLE edge where direction is 0000 or not one-hot, remain in IDLE and leave armed unchanged.
REQ-016 SHALL, on the IDLE -> FIRE edge, latch direction into shot_dir; shot_dir then holds until the next FIRE.
REQ-017 SHALL drive shoot_bullet = 1 only while in FIRE, i.e. for exactly one frame, one edge after fire_key is sampled.
REQ-018 SHALL increment shot_count by 1 on the FIRE -> FLIGHT edge, wrapping from 255 to 0.
REQ-019 SHALL always move FIRE -> FLIGHT after one frame and clear the flight counter at that transition.
REQ-020 SHALL, in FLIGHT, increment the flight counter each frame and leave FLIGHT when bullet_exists = 0 and the flight counter is at least 1.
REQ-021 SHALL also leave FLIGHT when the flight counter reaches FLIGHT_TIMEOUT, regardless of bullet_exists.
REQ-022 SHALL take the FLIGHT exit to COOL, loading the cooldown counter with COOLDOWN_FRAMES; if COOLDOWN_FRAMES = 0, the exit SHALL go directly to IDLE.
REQ-023 SHALL, in COOL, decrement the cooldown counter each frame and enter IDLE on the edge where the counter equals 1, so COOL lasts exactly COOLDOWN_FRAMES frames.
REQ-024 SHALL ignore fire_key presses in FIRE, FLIGHT and COOL; only armed tracking continues in those states.
REQ-025 SHALL, when fire_key = 1 and armed = 1 on the COOL -> IDLE edge, wait until the next edge before firing (no same-edge fire).
REQ-026 SHALL NOT register any change to direction during FLIGHT or COOL into shot_dir.

Reset
REQ-027 SHALL, while Reset = 1, immediately force state = IDLE, shoot_bullet = 0, shot_dir = 0000, busy = 0, shot_count = 0, armed = 0, and both counters = 0.
REQ-028 SHALL apply the same immediate reset mid-FIRE, mid-FLIGHT or mid-COOL, truncating any pulse in progress.
REQ-029 SHALL require fire_key to be seen low at least once after Reset deasserts before the first shot is allowed, because armed = 0 after reset.

Verification
REQ-030 SHALL cover: reset release, fire_key 0 for 1 frame then 1 with direction = 0001 -> shoot_bullet high exactly one frame, shot_dir = 0001, shot_count = 1.
REQ-031 SHALL cover: fire_key held high for 300 frames, with bullet_exists high for 60 frames after the pulse -> exactly one pulse, shot_count = 1.
REQ-032 SHALL cover: bullet_exists falls 60 frames after the shot, key re-pressed during COOL -> no pulse until COOL has lasted 8 frames, then a pulse on the next armed press.
REQ-033 SHALL cover: bullet_exists stuck at 1 -> FLIGHT exits after 127 frames, then 8 COOL frames, then busy = 0.
REQ-034 SHALL cover: Reset asserted mid-FLIGHT with shot_count = 5 -> all outputs 0 and state IDLE immediately; a held fire_key causes no shot until released.
REQ-035 SHALL cover: 256 complete shots -> shot_count wraps to 0; direction = 1100 with fire_key = 1 -> no shot and armed retained.
